// File: rtl/eth_pkg.sv
// Shared types and limits for the Ethernet TX arbitration path.
//   arb_state_t    : arbiter FSM state (idle arbitration cycle / frame transfer)
//   MAX_ARB_PORTS  : largest supported requester count
package eth_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_XFER
  } arb_state_t;

  localparam int unsigned MAX_ARB_PORTS = 8;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker.
//   req      : per-port request vector
//   ptr      : index of the port served last (lowest priority)
//   pick     : first requesting index scanning ptr+1, ptr+2, ... modulo NUM_PORTS
//   any_req  : at least one request present (pick is 0 when clear)
module eth_rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [PTR_WIDTH-1:0] pick,
  output logic                 any_req
);

  int unsigned          idx_int;
  logic [PTR_WIDTH-1:0] idx;
  logic                 found;

  assign any_req = |req;

  always_comb begin
    pick    = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    // i == NUM_PORTS wraps back to ptr itself, so the last-served port is scanned last.
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx_int = (32'(ptr) + i) % NUM_PORTS;
      idx     = PTR_WIDTH'(idx_int);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single MAC TX AXI-Stream slave.
// The grant is held from the first beat until the tlast handshake so frames never
// interleave; one idle arbitration cycle separates consecutive frames.
//   i_tx_clk, i_tx_reset_n       : sole clock, synchronous active-low reset
//   s_axis_*                     : NUM_PORTS flattened source streams (port p at slice p)
//   m_axis_*                     : merged stream to the MAC, combinational mux on o_grant
//   o_grant                      : registered one-hot grant, 0 while idle
//   o_busy                       : high while a frame is being transferred
//   o_frame_cnt                  : per-port completed frame counters (wrapping)
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           i_tx_clk,
  input  logic                           i_tx_reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]           s_axis_tlast,
  output logic [NUM_PORTS-1:0]           s_axis_trdy,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [CTRL_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_trdy,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic                           o_busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] o_frame_cnt
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_ARB_PORTS) begin : g_bad_num_ports
    $error("eth_tx_arbiter: NUM_PORTS must be within 2..%0d", MAX_ARB_PORTS);
  end

  arb_state_t                          state_q, state_d;
  logic [NUM_PORTS-1:0]                grant_q, grant_d;
  logic [PtrW-1:0]                     ptr_q, ptr_d;
  logic [PtrW-1:0]                     pick;
  logic                                any_req;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] cnt_q;
  logic                                frame_done;

  eth_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_WIDTH (PtrW)
  ) u_rr_pick (
    .req     (s_axis_tvalid),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  // Datapath: AND-OR mux on the registered one-hot grant; grant is 0 while idle,
  // so every output collapses to 0 there.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) begin
        m_axis_tdata  = m_axis_tdata | s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep  = m_axis_tkeep | s_axis_tkeep[p*CTRL_WIDTH +: CTRL_WIDTH];
        m_axis_tvalid = m_axis_tvalid | s_axis_tvalid[p];
        m_axis_tlast  = m_axis_tlast | s_axis_tlast[p];
      end
    end
    s_axis_trdy = grant_q & {NUM_PORTS{m_axis_trdy}};
  end

  assign o_busy     = (state_q == ARB_XFER);
  assign frame_done = o_busy & m_axis_tvalid & m_axis_trdy & m_axis_tlast;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          ptr_d         = pick;
          state_d       = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (frame_done) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  // ptr_q doubles as the granted index during XFER.
  always_ff @(posedge i_tx_clk) begin
    if (!i_tx_reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PtrW'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      if (frame_done) begin
        cnt_q[ptr_q] <= cnt_q[ptr_q] + CNT_WIDTH'(1);
      end
    end
  end

  assign o_grant     = grant_q;
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
module tb_eth_tx_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid, s_tlast;
  logic             m_trdy;

  logic [NP-1:0]    s_trdy, grant;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid, m_tlast, busy;
  logic [NP*16-1:0] frame_cnt;

  logic [NP-1:0]    s_trdy_w, grant_w;
  logic [DW-1:0]    m_tdata_w;
  logic [KW-1:0]    m_tkeep_w;
  logic             m_tvalid_w, m_tlast_w, busy_w;
  logic [NP*4-1:0]  frame_cnt_w;

  eth_tx_arbiter dut (
    .i_tx_clk      (clk),
    .i_tx_reset_n  (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_trdy   (s_trdy),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_trdy   (m_trdy),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_frame_cnt   (frame_cnt)
  );

  eth_tx_arbiter #(.CNT_WIDTH(4)) dut_w (
    .i_tx_clk      (clk),
    .i_tx_reset_n  (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_trdy   (s_trdy_w),
    .m_axis_tdata  (m_tdata_w),
    .m_axis_tkeep  (m_tkeep_w),
    .m_axis_tvalid (m_tvalid_w),
    .m_axis_tlast  (m_tlast_w),
    .m_axis_trdy   (m_trdy),
    .o_grant       (grant_w),
    .o_busy        (busy_w),
    .o_frame_cnt   (frame_cnt_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs driven, pre-edge outputs expected.
  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic        mr;
    logic [3:0]  g;
    logic [3:0]  t;
    logic        mv;
    logic        ml;
    logic        b;
    logic        cc;
    logic [63:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] vld, logic [3:0] lst, logic mr,
                              logic [3:0] g, logic [3:0] t, logic mv, logic ml, logic b,
                              logic cc, logic [63:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.mr = mr;
    v.g = g; v.t = t; v.mv = mv; v.ml = ml; v.b = b; v.cc = cc; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [DW-1:0] pdata(int p, int r);
    return {8'hD0, 8'(p), 8'(r), 8'h5A};
  endfunction

  function automatic logic [63:0] cnts(int c3, int c2, int c1, int c0);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_trdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    logic [KW-1:0] exp_k;
    logic [DW-1:0] base;
    int            beat, rx, sent;
    logic          hs_src;

    s_tdata = '0;
    s_tkeep = '0;

    // Single port 2 frame of 3 beats
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 4'b0100, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(0, 1, 0, 0)));
    // Reset, then all ports requesting 1-beat frames: 0,1,2,3,0 with bubbles
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 4'b0010, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 4'b0100, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 4'b1000, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(1, 1, 1, 2)));
    // Port 1 mid-frame while port 0 requests; one stalled beat
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0010, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 0, 4'b0010, 4'b0000, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0010, 1, 4'b0010, 4'b0010, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(1, 1, 2, 3)));
    // Request withdrawn right after being picked: grant held, XFER waits
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0100, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0100, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 4'b0100, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(1, 2, 2, 3)));
    // Reset during beat 2 of a port 0 frame; pointer reset gives port 0 the next grant
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0001, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0011, 4'b0000, 1, 4'b0001, 4'b0001, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(0, 0, 0, 0)));
    vecs.push_back(mk(0, 4'b0011, 4'b0001, 1, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, cnts(0, 0, 0, 1)));

    do_reset();
    @(negedge clk);
    chk("reset grant", 64'(grant), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset trdy", 64'(s_trdy), 0);
    chk("reset mvalid", 64'(m_tvalid), 0);
    chk("reset cnt", frame_cnt, 0);
    @(posedge clk);
    #1;

    foreach (vecs[r]) begin
      rst_n    = ~vecs[r].rst;
      s_tvalid = vecs[r].vld;
      s_tlast  = vecs[r].lst;
      m_trdy   = vecs[r].mr;
      for (int p = 0; p < NP; p++) begin
        s_tdata[p*DW +: DW] = pdata(p, r);
        s_tkeep[p*KW +: KW] = 4'(p + 1);
      end
      @(negedge clk);
      exp_d = '0;
      exp_k = '0;
      for (int p = 0; p < NP; p++) begin
        if (vecs[r].b && vecs[r].g[p]) begin
          exp_d = pdata(p, r);
          exp_k = 4'(p + 1);
        end
      end
      chk($sformatf("r%0d grant", r), 64'(grant), 64'(vecs[r].g));
      chk($sformatf("r%0d s_trdy", r), 64'(s_trdy), 64'(vecs[r].t));
      chk($sformatf("r%0d mvalid", r), 64'(m_tvalid), 64'(vecs[r].mv));
      chk($sformatf("r%0d mlast", r), 64'(m_tlast), 64'(vecs[r].ml));
      chk($sformatf("r%0d busy", r), 64'(busy), 64'(vecs[r].b));
      chk($sformatf("r%0d mdata", r), 64'(m_tdata), 64'(exp_d));
      chk($sformatf("r%0d mkeep", r), 64'(m_tkeep), 64'(exp_k));
      chk($sformatf("r%0d grant_w", r), 64'(grant_w), 64'(vecs[r].g));
      if (vecs[r].cc) chk($sformatf("r%0d frame_cnt", r), frame_cnt, vecs[r].cnt);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;

    // Backpressure: 4-beat port 1 frame, MAC stalls 5 cycles on beat 2
    do_reset();
    base = 32'h1100_0000;
    beat = 0;
    rx   = 0;
    for (int cyc = 0; cyc < 24 && rx < 4; cyc++) begin
      s_tvalid = (beat < 4) ? 4'b0010 : 4'b0000;
      s_tlast  = (beat == 3) ? 4'b0010 : 4'b0000;
      s_tdata[DW +: DW] = base + DW'(beat);
      m_trdy   = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      hs_src = s_trdy[1] && s_tvalid[1];
      if (m_tvalid && m_trdy) begin
        chk("bp data", 64'(m_tdata), 64'(base + DW'(rx)));
        chk("bp last", 64'(m_tlast), 64'(rx == 3));
        rx++;
      end else if (m_tvalid) begin
        chk("bp hold", 64'(m_tdata), 64'(base + DW'(rx)));
        chk("bp trdy", 64'(s_trdy), 0);
        chk("bp cnt", 64'(frame_cnt[16 +: 16]), 0);
      end
      @(posedge clk);
      #1;
      if (hs_src) beat++;
    end
    chk("bp beats", 64'(rx), 4);
    s_tvalid = '0;
    s_tlast  = '0;
    m_trdy   = 1'b1;
    @(negedge clk);
    chk("bp src beats", 64'(beat), 4);
    chk("bp final cnt", frame_cnt, cnts(0, 0, 1, 0));
    chk("bp idle grant", 64'(grant), 0);
    @(posedge clk);
    #1;

    // Counter wrap: port 3 sends 17 frames into a 4-bit counter
    do_reset();
    sent = 0;
    for (int cyc = 0; cyc < 80 && sent < 17; cyc++) begin
      s_tvalid = 4'b1000;
      s_tlast  = 4'b1000;
      m_trdy   = 1'b1;
      @(negedge clk);
      if (m_tvalid && m_trdy && m_tlast) sent++;
      @(posedge clk);
      #1;
    end
    chk("wrap frames", 64'(sent), 17);
    s_tvalid = '0;
    s_tlast  = '0;
    @(negedge clk);
    chk("wrap cnt_w", 64'(frame_cnt_w), 64'({4'd1, 4'd0, 4'd0, 4'd0}));
    chk("wrap cnt16", frame_cnt, cnts(17, 0, 0, 0));
    chk("wrap idle", 64'(busy_w), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
